// File: rtl/tinyalu_result_collector.sv
// rtl/tinyalu_result_collector.sv - TinyALU pin observer pairing operations with results into a record FIFO
// Optional result checker: define TINYALU_RESULT_CHECK_EN.
module tinyalu_result_collector #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32,
    parameter int DROP_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [2:0]               op,
    input  logic [7:0]               A,
    input  logic [7:0]               B,
    input  logic                     done,
    input  logic [15:0]              result,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [2:0]               rec_op,
    output logic [7:0]               rec_a,
    output logic [7:0]               rec_b,
    output logic [15:0]              rec_result,
    output logic                     rec_timeout,
    output logic                     rec_mismatch,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int REC_W = 3 + 8 + 8 + 16 + 1 + 1;

    typedef enum logic [1:0] {IDLE, BUSY, WAIT_LOW} state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   timer;
    logic [2:0]      cap_op;
    logic [7:0]      cap_a, cap_b;
    logic            capture, push, push_timeout, push_mis;
    logic [15:0]     push_result;
    logic [REC_W-1:0] push_rec, head;

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full, pop, accept;

    always_comb begin
        state_nxt    = state;
        capture      = 1'b0;
        push         = 1'b0;
        push_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (start && op >= 3'd1 && op <= 3'd4) begin
                    capture   = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                // done on the final timer cycle still wins over the timeout
                if (done) begin
                    push      = 1'b1;
                    state_nxt = WAIT_LOW;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    push         = 1'b1;
                    push_timeout = 1'b1;
                    state_nxt    = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!start) state_nxt = IDLE;
            end
            default: state_nxt = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= WAIT_LOW;
            timer  <= '0;
            cap_op <= '0;
            cap_a  <= '0;
            cap_b  <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                cap_op <= op;
                cap_a  <= A;
                cap_b  <= B;
                timer  <= '0;
            end else if (state == BUSY) begin
                timer <= timer + TW'(1);
            end
        end
    end

    assign push_result = push_timeout ? 16'h0 : result;

`ifdef TINYALU_RESULT_CHECK_EN
    logic [15:0] expected;
    always_comb begin
        expected = 16'h0;
        case (cap_op)
            3'd1:    expected = {8'h0, cap_a} + {8'h0, cap_b};
            3'd2:    expected = {8'h0, cap_a & cap_b};
            3'd3:    expected = {8'h0, cap_a ^ cap_b};
            3'd4:    expected = {8'h0, cap_a} * {8'h0, cap_b};
            default: expected = 16'h0;
        endcase
    end
    assign push_mis = (result != expected) & ~push_timeout;
`else
    assign push_mis = 1'b0;
`endif

    assign push_rec = {cap_op, cap_a, cap_b, push_result, push_timeout, push_mis};

    assign full   = (count == CW'(DEPTH));
    assign pop    = (count != '0) && rec_ready;
    assign accept = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!reset && accept) mem[wr_ptr] <= push_rec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            if (accept && !pop)      count <= count + CW'(1);
            else if (!accept && pop) count <= count - CW'(1);
            if (push && !accept && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

    // Head is masked so every record field reads 0 while the FIFO is empty
    assign head       = mem[rd_ptr];
    assign rec_valid  = (count != '0);
    assign fifo_count = count;
    assign {rec_op, rec_a, rec_b, rec_result, rec_timeout, rec_mismatch} =
        rec_valid ? head : '0;

endmodule

// File: doc/tinyalu_result_collector.md
Name: tinyalu_result_collector

Overview:
- Synthesizable RTL observer on the TinyALU pin interface. Pairs each operation accepted on start/op/A/B with its done/result, or with a timeout.
- Packs each pair into a record and buffers records in a small FIFO.
- Presents records on a valid/ready port for downstream consumers (scoreboard bridge, result printer transactor).
- Producer-side counterpart of the result consumer in the TLM bench.

Parameters:
- DEPTH, 4, record FIFO entries; power of 2, minimum 2.
- TIMEOUT, 32, cycles allowed between capture and done; minimum 2.
- DROP_W, 8, width of the saturating dropped-record counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  TinyALU start, observed.
- op  in  3  TinyALU opcode, observed.
- A  in  8  operand A, observed.
- B  in  8  operand B, observed.
- done  in  1  TinyALU done, observed.
- result  in  16  TinyALU result, observed.
- rec_valid  out  1  head record available.
- rec_ready  in  1  consumer accepts head record.
- rec_op  out  3  captured opcode.
- rec_a  out  8  captured A.
- rec_b  out  8  captured B.
- rec_result  out  16  sampled result; 0 on timeout.
- rec_timeout  out  1  record closed by timeout.
- rec_mismatch  out  1  result differs from expected; see Optional Feature.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.
- drop_cnt  out  DROP_W  records lost to a full FIFO; saturating.

Behaviour:
- Reset: clk rising edge with reset=1 clears FIFO, drop_cnt and timer; FSM goes to WAIT_LOW. All outputs read 0, including rec_valid and fifo_count.
- Reset mid-operation discards the in-flight capture. Any start still high after reset is not captured.
- FSM states:
  - IDLE: if start=1 and op in 1..4, latch op/A/B, timer=0, go to BUSY. op 0 or 5..7 with start=1 is ignored and the FSM stays in IDLE. done in IDLE is ignored.
  - BUSY: timer increments each cycle.
    - If done=1: push {op,A,B,result,timeout=0}, go to WAIT_LOW.
    - Else if timer==TIMEOUT-1: push {op,A,B,16'h0,timeout=1}, go to WAIT_LOW.
    - done on the timeout cycle counts as done, not timeout.
  - WAIT_LOW: go to IDLE on the first cycle with start=0. Prevents recapture of a start held high past done.
- Latency: minimum 1 cycle from the capture edge to done sampling. A record is visible on rec_valid the cycle after its push.
- FIFO:
  - Head drives rec_*. rec_valid = not empty.
  - Pop on rec_valid & rec_ready.
  - rec_* hold stable while rec_valid=1 and rec_ready=0.
  - Push when full and no pop: record dropped, drop_cnt += 1, saturating at all-ones.
  - Push when full with a simultaneous pop: push accepted, count unchanged.
  - Push when empty: no same-cycle bypass.
  - Pointers wrap modulo DEPTH.
- Widths: result and expected values are 16-bit unsigned; 8-bit operands are zero-extended.

Optional Feature:
- Macro: TINYALU_RESULT_CHECK_EN.
- Defined: at push time compute expected = A+B (op1), A&B (op2), A^B (op3), A*B (op4). rec_mismatch = (result != expected) & ~timeout, stored with the record.
- Undefined: no checker logic; rec_mismatch is tied to 0.

Test Plan:
- reset 3 cycles, start high through and after reset -> no record; rec_valid=0, fifo_count=0, drop_cnt=0 until start drops and a new op starts.
- op=1, A=8'hFF, B=8'h01, done one cycle later with result=16'h0100 -> one record {1,FF,01,0100,timeout=0,mismatch=0}, rec_valid the cycle after done.
- op=4, A=8'hFF, B=8'hFF, done never asserted -> record after TIMEOUT cycles with result=0, timeout=1; start held high afterwards produces no second record.
- rec_ready=0, five back-to-back add ops with DEPTH=4 -> fifo_count=4, drop_cnt=1, head record held stable. Then rec_ready=1 -> four records drain in order.
- FIFO full, push and pop in the same cycle -> push accepted, fifo_count stays 4, drop_cnt unchanged.
- With TINYALU_RESULT_CHECK_EN: op=3, A=8'hF0, B=8'h0F, result=16'h00FE -> mismatch=1; result=16'h00FF -> mismatch=0. Without the macro, both give mismatch=0.
